// File: rtl/mips32_pkg.sv
// mips32_pkg: shared types and constants for the MIPS32 memory responder.
//   state_t    - responder FSM states (IDLE, WAIT, RESP)
//   HLT_OPCODE - opcode field value of the halt instruction
//   is_hlt()   - true when a 32-bit word carries the HLT opcode
package mips32_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [5:0] HLT_OPCODE = 6'h3f;

    function automatic logic is_hlt(input logic [31:0] word);
        return word[31:26] == HLT_OPCODE;
    endfunction

endpackage

// File: rtl/mips32_word_ram.sv
// mips32_word_ram: single-port word array, synchronous write and
// asynchronous (combinational) read on the same address.
//   clk   - write clock
//   we    - write enable
//   addr  - word address shared by the read and write paths
//   wdata - write data
//   rdata - contents of mem[addr]
// The array has no reset, so contents survive a responder reset.
module mips32_word_ram #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mips32_mem_responder.sv
// mips32_mem_responder: word memory that answers CPU load/store requests
// with a fixed number of wait states, plus a preload port.
//   clk1, rst_n                   - clock, synchronous active-low reset
//   req_valid/req_ready           - request handshake
//   req_we, req_addr, req_wdata   - request payload (word address)
//   rsp_valid/rsp_ready           - response handshake
//   rsp_rdata, rsp_err            - response payload (zero outside RESP)
//   load_en, load_addr, load_data - preload write, any state, wins over requests
//   halt_seen                     - sticky: a HLT word was returned by a load
module mips32_mem_responder
    import mips32_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [31:0]       load_data,
    output logic              halt_seen
);

    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] rsp_data_q;
    logic        rsp_err_q;
    logic        rsp_we_q;
    logic        halt_q;

    logic        accept;
    logic        in_range;
    logic        ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    generate
        if (ADDR_W >= 32) begin : g_full
            assign in_range = 1'b1;
        end else begin : g_part
            assign in_range = (req_addr[31:ADDR_W] == '0);
        end
    endgenerate

    assign req_ready = (state == ST_IDLE) && !load_en;
    assign accept    = req_valid && req_ready;

    // Preload owns the single RAM port whenever it is active; a request can
    // only be accepted when load_en is low, so the two never collide.
    assign ram_we    = load_en || (accept && req_we && in_range);
    assign ram_addr  = load_en ? load_addr : req_addr[ADDR_W-1:0];
    assign ram_wdata = load_en ? load_data : req_wdata;

    mips32_word_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk   (clk1),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= 4'd0;
            rsp_data_q <= 32'd0;
            rsp_err_q  <= 1'b0;
            rsp_we_q   <= 1'b0;
            halt_q     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        rsp_we_q  <= req_we;
                        rsp_err_q <= !in_range;
                        // Read data is snapshotted here so later preloads
                        // cannot disturb a pending response.
                        if (!in_range)   rsp_data_q <= 32'd0;
                        else if (req_we) rsp_data_q <= req_wdata;
                        else             rsp_data_q <= ram_rdata;
                        if (WAIT_CYCLES > 0) begin
                            state <= ST_WAIT;
                            cnt   <= WAIT_INIT;
                        end else begin
                            state <= ST_RESP;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt == 4'd0) state <= ST_RESP;
                    else             cnt   <= cnt - 4'd1;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state <= ST_IDLE;
                        if (!rsp_we_q && !rsp_err_q && is_hlt(rsp_data_q))
                            halt_q <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign rsp_valid = (state == ST_RESP);
    assign rsp_rdata = rsp_valid ? rsp_data_q : 32'd0;
    assign rsp_err   = rsp_valid && rsp_err_q;
    assign halt_seen = halt_q;

endmodule

// File: tb/tb_mips32_mem_responder.sv
// Self-checking bench for mips32_mem_responder: directed scenarios followed
// by randomized accesses, compared against a word-array reference model.
module tb_mips32_mem_responder;

    localparam int ADDR_W      = 10;
    localparam int WAIT_CYCLES = 1;
    localparam int DEPTH       = 1 << ADDR_W;

    logic              clk1 = 1'b0;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [31:0]       load_data;
    logic              halt_seen;

    int checks = 0;
    int errors = 0;

    logic [31:0] model_mem [DEPTH];
    logic        model_halt;

    mips32_mem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(WAIT_CYCLES)) dut (
        .clk1      (clk1),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .halt_seen (halt_seen)
    );

    always #5 clk1 = ~clk1;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk1);
        #1;
    endtask

    // One preload cycle with a conflicting request also offered: the request
    // must not be accepted while load_en is high.
    task automatic preload(input int addr, input logic [31:0] data);
        load_en   = 1'b1;
        load_addr = ADDR_W'(addr);
        load_data = data;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'(addr);
        req_wdata = ~data;
        #1;
        check1("ready_during_load", req_ready, 1'b0);
        step();
        load_en   = 1'b0;
        req_valid = 1'b0;
        model_mem[addr] = data;
    endtask

    // Full access: handshake, exact latency, hold in RESP, completion.
    // load_mid writes load_val to the same word during the first wait cycle.
    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          input int hold, input bit load_mid, input logic [31:0] load_val);
        logic [31:0] exp_d;
        logic        exp_e;
        bit          got;
        int          idx;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        rsp_ready = (hold == 0);
        got = 0;
        for (int i = 0; i < 20; i++) begin
            #0;
            if (req_ready === 1'b1) begin
                got = 1;
                break;
            end
            step();
        end
        check1("req_ready_idle", got, 1'b1);
        exp_e = (addr >= 32'(DEPTH));
        idx   = int'(addr) % DEPTH;
        if (exp_e)   exp_d = 32'd0;
        else if (we) exp_d = wd;
        else         exp_d = model_mem[idx];
        if (we && !exp_e) model_mem[idx] = wd;
        step();
        req_valid = 1'b0;
        for (int k = 1; k <= WAIT_CYCLES; k++) begin
            check1("rsp_valid_early", rsp_valid, 1'b0);
            check32("rdata_outside_resp", rsp_rdata, 32'd0);
            if (load_mid && k == 1) begin
                load_en   = 1'b1;
                load_addr = ADDR_W'(idx);
                load_data = load_val;
                model_mem[idx] = load_val;
            end
            step();
            load_en = 1'b0;
        end
        check1("rsp_valid_latency", rsp_valid, 1'b1);
        check32("rsp_rdata", rsp_rdata, exp_d);
        check1("rsp_err", rsp_err, exp_e);
        check1("req_ready_in_resp", req_ready, 1'b0);
        for (int h = 1; h < hold; h++) begin
            step();
            check1("hold_valid", rsp_valid, 1'b1);
            check32("hold_rdata", rsp_rdata, exp_d);
            check1("hold_req_ready", req_ready, 1'b0);
        end
        rsp_ready = 1'b1;
        step();
        if (!we && !exp_e && exp_d[31:26] == 6'h3f) model_halt = 1'b1;
        check1("done_valid_low", rsp_valid, 1'b0);
        check32("done_rdata_zero", rsp_rdata, 32'd0);
        check1("done_req_ready", req_ready, 1'b1);
        check1("halt_seen", halt_seen, model_halt);
    endtask

    // Accept a request, then assert reset during its wait state.
    task automatic reset_in_wait(input logic we, input int addr, input logic [31:0] wd);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = 32'(addr);
        req_wdata = wd;
        rsp_ready = 1'b1;
        #1;
        check1("rw_req_ready", req_ready, 1'b1);
        if (we) model_mem[addr] = wd;
        step();
        req_valid = 1'b0;
        check1("rw_in_wait", rsp_valid, 1'b0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        model_halt = 1'b0;
        check1("rw_valid_after_rst", rsp_valid, 1'b0);
        check1("rw_ready_after_rst", req_ready, 1'b1);
        check1("rw_halt_cleared", halt_seen, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            check1("rw_no_response", rsp_valid, 1'b0);
        end
    endtask

    initial begin
        logic [31:0] a, d;
        int          hold;
        logic        we;

        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0;
        req_wdata = 32'd0; rsp_ready = 1'b0; load_en = 1'b0; load_addr = '0;
        load_data = 32'd0; model_halt = 1'b0;
        step();
        step();
        check1("rst_rsp_valid", rsp_valid, 1'b0);
        check1("rst_rsp_err", rsp_err, 1'b0);
        check32("rst_rsp_rdata", rsp_rdata, 32'd0);
        check1("rst_halt_seen", halt_seen, 1'b0);
        rst_n = 1'b1;
        #1;
        check1("ready_after_release", req_ready, 1'b1);

        // Known, halt-free contents for the low 32 words.
        for (int i = 0; i < 32; i++) preload(i, $urandom & 32'h03ff_ffff);
        preload(1, 32'h2802_0014);
        preload(8, 32'hfc00_0000);

        access(1'b0, 32'd1, 32'd0, 0, 0, 32'd0);
        access(1'b1, 32'd5, 32'hdead_beef, 0, 0, 32'd0);
        access(1'b0, 32'd5, 32'd0, 0, 0, 32'd0);
        access(1'b0, 32'h0000_0400, 32'd0, 0, 0, 32'd0);
        access(1'b1, 32'h0000_0405, 32'h1234_5678, 0, 0, 32'd0);
        access(1'b0, 32'd5, 32'd0, 0, 0, 32'd0);
        access(1'b0, 32'd1, 32'd0, 4, 0, 32'd0);
        access(1'b1, 32'd12, 32'hfc00_0000, 0, 0, 32'd0);
        access(1'b0, 32'd8, 32'd0, 2, 0, 32'd0);

        // Store persists across a reset that abandons its response.
        reset_in_wait(1'b1, 9, 32'h0bad_cafe);
        access(1'b0, 32'd9, 32'd0, 0, 0, 32'd0);
        reset_in_wait(1'b0, 3, 32'd0);

        // Preload during wait must not alter the pending read.
        access(1'b0, 32'd7, 32'd0, 1, 1, 32'h5555_aaaa);
        access(1'b0, 32'd7, 32'd0, 0, 0, 32'd0);

        for (int n = 0; n < 60; n++) begin
            we   = 1'($urandom_range(0, 1));
            hold = $urandom_range(0, 3);
            d    = $urandom;
            if ($urandom_range(0, 7) == 0) a = 32'h400 + ($urandom & 32'h0fff_ffff);
            else                           a = 32'($urandom_range(0, 31));
            access(we, a, d, hold, 0, 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
